// File: rtl/local_ingress_buffer.sv
// Local ingress port: PE request/grant handshake into a small FIFO, head presented with an XY route.
// Optional LOCAL_INGRESS_STATS_EN adds saturating accept/drop counters.
module local_ingress_buffer #(
    parameter int         DATA_WIDTH = 32,
    parameter int         DEPTH      = 4,
    parameter logic [1:0] ROUTER_X   = 2'd0,
    parameter logic [1:0] ROUTER_Y   = 2'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ReqUpStr,
    input  logic [DATA_WIDTH-1:0] PacketIn,
    output logic                  GntUpStr,
    output logic                  UpStrFull,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic [DATA_WIDTH-1:0] flit_data,
    output logic [4:0]            out_port,
    output logic                  drop_pulse
`ifdef LOCAL_INGRESS_STATS_EN
    ,
    output logic [15:0]           accept_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {G_IDLE, G_GNT} gstate_t;

    gstate_t               r_state;
    logic                  r_gnt;
    logic                  r_drop;
    logic                  r_full;
    logic [CW-1:0]         r_count;
    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_typeOk;
    logic                  w_write;
    logic                  w_valid;
    logic                  w_pop;
    logic [CW-1:0]         w_countNext;
    logic [DATA_WIDTH-1:0] w_head;
    logic [1:0]            w_destX;
    logic [1:0]            w_destY;

    // Eligibility uses the pre-pop full flag, so a full FIFO never takes a write even while popping.
    assign w_accept    = (r_state == G_IDLE) && ReqUpStr && !r_full;
    assign w_typeOk    = (PacketIn[31:30] == 2'b01);
    assign w_write     = w_accept && w_typeOk;
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && flit_ready;
    assign w_countNext = r_count + CW'(w_write) - CW'(w_pop);

    assign w_head  = r_mem[r_rdPtr];
    assign w_destX = w_head[27:26];
    assign w_destY = w_head[25:24];

    assign GntUpStr   = r_gnt;
    assign drop_pulse = r_drop;
    assign UpStrFull  = r_full;
    assign flit_valid = w_valid;
    assign flit_data  = w_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= G_IDLE;
            r_gnt   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                G_IDLE: begin
                    if (w_accept) begin
                        r_gnt   <= 1'b1;
                        r_drop  <= !w_typeOk;
                        r_state <= G_GNT;
                    end else begin
                        r_gnt  <= 1'b0;
                        r_drop <= 1'b0;
                    end
                end
                G_GNT: begin
                    r_gnt   <= 1'b0;
                    r_drop  <= 1'b0;
                    r_state <= G_IDLE;
                end
                default: begin
                    r_gnt   <= 1'b0;
                    r_drop  <= 1'b0;
                    r_state <= G_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            r_count <= w_countNext;
            r_full  <= (w_countNext == CW'(DEPTH));
            if (w_write) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage needs no reset; entries are only observed once written.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= PacketIn;
        end
    end

    // Dimension-order routing: resolve X first, then Y, else deliver locally.
    always_comb begin
        out_port = 5'b00000;
        if (w_valid) begin
            if (w_destX > ROUTER_X) begin
                out_port = 5'b00100;
            end else if (w_destX < ROUTER_X) begin
                out_port = 5'b10000;
            end else if (w_destY > ROUTER_Y) begin
                out_port = 5'b00010;
            end else if (w_destY < ROUTER_Y) begin
                out_port = 5'b01000;
            end else begin
                out_port = 5'b00001;
            end
        end
    end

`ifdef LOCAL_INGRESS_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accept_cnt <= 16'h0000;
            drop_cnt   <= 16'h0000;
        end else begin
            if (w_write && accept_cnt != 16'hFFFF) begin
                accept_cnt <= accept_cnt + 16'h0001;
            end
            if (w_accept && !w_typeOk && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_local_ingress_buffer.sv
// Bench for local_ingress_buffer: two routers (0,0) and (1,1) share one PE stream, checked
// every cycle against a queue-based reference model.
module tb_local_ingress_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ReqUpStr = 1'b0;
    logic [31:0] PacketIn = 32'h0;
    logic        flit_ready = 1'b0;

    logic        gnt0, full0, valid0, drop0;
    logic [31:0] data0;
    logic [4:0]  port0;
    logic        gnt1, full1, valid1, drop1;
    logic [31:0] data1;
    logic [4:0]  port1;
`ifdef LOCAL_INGRESS_STATS_EN
    logic [15:0] acc0, dcnt0, acc1, dcnt1;
`endif

    logic [31:0] q[$];
    bit          mGnt = 1'b0;
    bit          mDrop = 1'b0;
    int          mAcc = 0;
    int          mDropCnt = 0;
    bit          autoReq = 1'b0;
    int          nAsserts = 0;
    int          nFail = 0;
    int          lat;

    always #5 clk = ~clk;

    local_ingress_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ROUTER_X(2'd0), .ROUTER_Y(2'd0)) dut0 (
        .clk(clk), .rst(rst), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
        .GntUpStr(gnt0), .UpStrFull(full0), .flit_valid(valid0), .flit_ready(flit_ready),
        .flit_data(data0), .out_port(port0), .drop_pulse(drop0)
`ifdef LOCAL_INGRESS_STATS_EN
        , .accept_cnt(acc0), .drop_cnt(dcnt0)
`endif
    );

    local_ingress_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ROUTER_X(2'd1), .ROUTER_Y(2'd1)) dut1 (
        .clk(clk), .rst(rst), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
        .GntUpStr(gnt1), .UpStrFull(full1), .flit_valid(valid1), .flit_ready(flit_ready),
        .flit_data(data1), .out_port(port1), .drop_pulse(drop1)
`ifdef LOCAL_INGRESS_STATS_EN
        , .accept_cnt(acc1), .drop_cnt(dcnt1)
`endif
    );

    // Expected one-hot route from the XY rule applied to a packet header.
    function automatic logic [4:0] routeOf(input logic [31:0] p, input int rx, input int ry);
        int dx, dy;
        dx = int'(p[27:26]);
        dy = int'(p[25:24]);
        if (dx > rx)      return 5'b00100;
        else if (dx < rx) return 5'b10000;
        else if (dy > ry) return 5'b00010;
        else if (dy < ry) return 5'b01000;
        else              return 5'b00001;
    endfunction

    function automatic logic [31:0] randPkt();
        logic [31:0] p;
        p = $urandom;
        if ($urandom_range(0, 7) != 0) p[31:30] = 2'b01;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        bit ne;
        ne = (q.size() > 0);
        checkOutput("gnt0", 32'(gnt0), 32'(mGnt));
        checkOutput("gnt1", 32'(gnt1), 32'(mGnt));
        checkOutput("drop0", 32'(drop0), 32'(mDrop));
        checkOutput("drop1", 32'(drop1), 32'(mDrop));
        checkOutput("full0", 32'(full0), 32'(q.size() == DEPTH));
        checkOutput("full1", 32'(full1), 32'(q.size() == DEPTH));
        checkOutput("valid0", 32'(valid0), 32'(ne));
        checkOutput("valid1", 32'(valid1), 32'(ne));
        checkOutput("port0", 32'(port0), ne ? 32'(routeOf(q[0], 0, 0)) : 32'h0);
        checkOutput("port1", 32'(port1), ne ? 32'(routeOf(q[0], 1, 1)) : 32'h0);
        if (ne) begin
            checkOutput("data0", data0, q[0]);
            checkOutput("data1", data1, q[0]);
        end
`ifdef LOCAL_INGRESS_STATS_EN
        checkOutput("acceptCnt", 32'(acc0), 32'(mAcc));
        checkOutput("dropCnt", 32'(dcnt0), 32'(mDropCnt));
        checkOutput("acceptCnt1", 32'(acc1), 32'(mAcc));
`endif
    endtask

    // One clock: predict the edge from current inputs, advance, check, then let the PE react.
    task automatic cycle();
        bit          acc, typeOk, pop;
        logic [31:0] pkt;
        acc    = !mGnt && ReqUpStr && (q.size() < DEPTH);
        typeOk = (PacketIn[31:30] == 2'b01);
        pop    = (q.size() > 0) && flit_ready;
        pkt    = PacketIn;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc && typeOk) begin
            q.push_back(pkt);
            if (mAcc < 65535) mAcc++;
        end
        if (acc && !typeOk && mDropCnt < 65535) mDropCnt++;
        mGnt  = acc;
        mDrop = acc && !typeOk;
        checkAll();
        if (ReqUpStr && gnt0) ReqUpStr = 1'b0;
        if (autoReq && !ReqUpStr && $urandom_range(0, 1) == 1) begin
            ReqUpStr = 1'b1;
            PacketIn = randPkt();
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pkt);
        ReqUpStr = 1'b1;
        PacketIn = pkt;
        for (int i = 0; i < 20 && ReqUpStr; i++) cycle();
        checkOutput("grantTimeout", 32'(ReqUpStr), 32'h0);
    endtask

    task automatic drain();
        flit_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 4 && q.size() > 0; i++) cycle();
        flit_ready = 1'b0;
        cycle();
    endtask

    initial begin
        #3;
        checkAll();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        $display("[TB] single packet");
        applyStimulus(32'h5A00_1234);
        checkOutput("singleRoute", 32'(port0), 32'h04);
        cycle();
        drain();

        $display("[TB] fill, stall, pop, resume");
        applyStimulus({2'b01, 2'b00, 2'd3, 2'd0, 24'h000001});
        applyStimulus({2'b01, 2'b01, 2'd0, 2'd2, 24'h000002});
        applyStimulus({2'b01, 2'b10, 2'd1, 2'd1, 24'h000003});
        applyStimulus({2'b01, 2'b11, 2'd0, 2'd0, 24'h000004});
        checkOutput("fullAfter4", 32'(full0), 32'h1);
        ReqUpStr = 1'b1;
        PacketIn = {2'b01, 2'b00, 2'd2, 2'd3, 24'h000005};
        repeat (3) cycle();
        checkOutput("stalledReq", 32'(ReqUpStr), 32'h1);
        flit_ready = 1'b1;
        cycle();
        flit_ready = 1'b0;
        lat = 0;
        while (ReqUpStr && lat < 4) begin
            cycle();
            lat++;
        end
        checkOutput("grantAfterPop", 32'(lat <= 2 && !ReqUpStr), 32'h1);
        drain();

        $display("[TB] malformed header");
        applyStimulus(32'h9400_0001);
        checkOutput("dropSeen", 32'(drop0), 32'h1);
        cycle();
        checkOutput("dropOneCycle", 32'(drop0), 32'h0);

        $display("[TB] routes at (1,1)");
        applyStimulus({2'b01, 2'b00, 2'd1, 2'd1, 24'h000011});
        applyStimulus({2'b01, 2'b00, 2'd1, 2'd2, 24'h000012});
        applyStimulus({2'b01, 2'b00, 2'd1, 2'd0, 24'h000010});
        applyStimulus({2'b01, 2'b00, 2'd0, 2'd3, 24'h000003});
        checkOutput("routeLocal", 32'(port1), 32'h01);
        drain();

        $display("[TB] full with ready held, pointer wrap");
        for (int i = 0; i < DEPTH; i++) applyStimulus({2'b01, 6'($urandom), 24'($urandom)});
        flit_ready = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus({2'b01, 6'($urandom), 24'($urandom)});
        drain();

        $display("[TB] random traffic");
        autoReq = 1'b1;
        for (int i = 0; i < 300; i++) begin
            flit_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        autoReq = 1'b0;
        for (int i = 0; i < 20 && ReqUpStr; i++) cycle();
        drain();

        $display("[TB] async reset mid-grant");
        applyStimulus({2'b01, 2'b00, 2'd2, 2'd2, 24'h0000A1});
        applyStimulus({2'b01, 2'b00, 2'd0, 2'd1, 24'h0000A2});
        applyStimulus({2'b01, 2'b00, 2'd3, 2'd3, 24'h0000A3});
        checkOutput("preResetGnt", 32'(gnt0), 32'h1);
        #2;
        rst = 1'b1;
        ReqUpStr = 1'b0;
        #1;
        q.delete();
        mGnt = 1'b0;
        mDrop = 1'b0;
        mAcc = 0;
        mDropCnt = 0;
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        rst = 1'b0;
        applyStimulus({2'b01, 2'b00, 2'd0, 2'd0, 24'h0000B0});
        checkOutput("postResetValid", 32'(valid0), 32'h1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
